// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32I decode constants for the ID stage slice.
// Holds the opcode encodings, the immediate-format enum and the register
// address width used by id_stage and rv_imm_gen.
package rv32_pkg;

    localparam int REG_ADDR_WIDTH = 5;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } imm_fmt_e;

endpackage

// File: rtl/rv_imm_gen.sv
// rv_imm_gen: combinational RV32I immediate extractor.
// Reassembles the immediate of the given format and sign-extends it to
// REG_DATA_WIDTH (which must be at least 32). R-type yields zero.
module rv_imm_gen
    import rv32_pkg::*;
#(
    parameter int REG_DATA_WIDTH = 32
) (
    input  logic [31:0]               i_instr,
    input  imm_fmt_e                  i_fmt,
    output logic [REG_DATA_WIDTH-1:0] o_imm
);

    logic [31:0] w_imm32;

    // Scatter the instruction bits back into a 32-bit immediate per format.
    always_comb begin
        w_imm32 = '0;
        case (i_fmt)
            FMT_I:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            FMT_S:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            FMT_B:   w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                                i_instr[30:25], i_instr[11:8], 1'b0};
            FMT_U:   w_imm32 = {i_instr[31:12], 12'b0};
            FMT_J:   w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                                i_instr[20], i_instr[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase
    end

    // Widen to the datapath width, replicating the sign bit.
    always_comb begin
        o_imm        = {REG_DATA_WIDTH{w_imm32[31]}};
        o_imm[31:0]  = w_imm32;
    end

endmodule

// File: rtl/id_stage.sv
// id_stage: RV32I decode stage sitting in front of the GPREGS register file.
// Decodes the offered instruction, reads rs1/rs2 combinationally, stalls on
// RAW hazards tracked by a 32-entry busy scoreboard, and registers the result
// into a single ID/EX slot with a valid/ready handshake.
// Optional macro ID_FORWARD_WB_EN: bypass same-cycle writeback data into the
// operands and ignore the busy bit it is about to clear.
module id_stage
    import rv32_pkg::*;
#(
    parameter int REG_DATA_WIDTH = 32
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      if_valid,
    output logic                      if_ready,
    input  logic [31:0]               if_instr,
    input  logic [REG_DATA_WIDTH-1:0] if_pc,
    output logic [REG_ADDR_WIDTH-1:0] read_reg_0,
    output logic [REG_ADDR_WIDTH-1:0] read_reg_1,
    input  logic [REG_DATA_WIDTH-1:0] dout_reg_0,
    input  logic [REG_DATA_WIDTH-1:0] dout_reg_1,
    input  logic                      wb_en,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
    input  logic [REG_DATA_WIDTH-1:0] wb_data,
    input  logic                      flush,
    output logic                      ex_valid,
    input  logic                      ex_ready,
    output logic [REG_DATA_WIDTH-1:0] ex_pc,
    output logic [REG_DATA_WIDTH-1:0] ex_rs1_val,
    output logic [REG_DATA_WIDTH-1:0] ex_rs2_val,
    output logic [REG_DATA_WIDTH-1:0] ex_imm,
    output logic [REG_ADDR_WIDTH-1:0] ex_rd,
    output logic [6:0]                ex_opcode,
    output logic [2:0]                ex_funct3,
    output logic [6:0]                ex_funct7,
    output logic                      ex_we,
    output logic                      ex_illegal
);

    logic [6:0]                w_opcode;
    logic [REG_ADDR_WIDTH-1:0] w_rd;
    logic [REG_ADDR_WIDTH-1:0] w_rs1;
    logic [REG_ADDR_WIDTH-1:0] w_rs2;
    logic [2:0]                w_funct3;
    logic [6:0]                w_funct7;
    logic                      w_usesRs1;
    logic                      w_usesRs2;
    logic                      w_writesRd;
    logic                      w_illegal;
    imm_fmt_e                  w_fmt;
    logic [REG_DATA_WIDTH-1:0] w_imm;
    logic                      w_fwd1;
    logic                      w_fwd2;
    logic                      w_haz1;
    logic                      w_haz2;
    logic                      w_accept;
    logic                      w_issue;
    logic [REG_DATA_WIDTH-1:0] w_rs1Val;
    logic [REG_DATA_WIDTH-1:0] w_rs2Val;

    logic [31:0]               r_busy;
    logic                      r_exValid;
    logic [REG_DATA_WIDTH-1:0] r_exPc;
    logic [REG_DATA_WIDTH-1:0] r_exRs1Val;
    logic [REG_DATA_WIDTH-1:0] r_exRs2Val;
    logic [REG_DATA_WIDTH-1:0] r_exImm;
    logic [REG_ADDR_WIDTH-1:0] r_exRd;
    logic [6:0]                r_exOpcode;
    logic [2:0]                r_exFunct3;
    logic [6:0]                r_exFunct7;
    logic                      r_exWe;
    logic                      r_exIllegal;

    assign w_opcode   = if_instr[6:0];
    assign w_rd       = if_instr[11:7];
    assign w_funct3   = if_instr[14:12];
    assign w_rs1      = if_instr[19:15];
    assign w_rs2      = if_instr[24:20];
    assign w_funct7   = if_instr[31:25];
    assign read_reg_0 = w_rs1;
    assign read_reg_1 = w_rs2;

    // Classify the opcode: which registers it reads/writes and its immediate format.
    always_comb begin
        w_usesRs1  = 1'b0;
        w_usesRs2  = 1'b0;
        w_writesRd = 1'b0;
        w_illegal  = 1'b0;
        w_fmt      = FMT_R;
        case (w_opcode)
            OPC_LUI, OPC_AUIPC: begin
                w_writesRd = 1'b1;
                w_fmt      = FMT_U;
            end
            OPC_JAL: begin
                w_writesRd = 1'b1;
                w_fmt      = FMT_J;
            end
            OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
                w_writesRd = 1'b1;
                w_usesRs1  = 1'b1;
                w_fmt      = FMT_I;
            end
            OPC_BRANCH: begin
                w_usesRs1 = 1'b1;
                w_usesRs2 = 1'b1;
                w_fmt     = FMT_B;
            end
            OPC_STORE: begin
                w_usesRs1 = 1'b1;
                w_usesRs2 = 1'b1;
                w_fmt     = FMT_S;
            end
            OPC_OP: begin
                w_writesRd = 1'b1;
                w_usesRs1  = 1'b1;
                w_usesRs2  = 1'b1;
                w_fmt      = FMT_R;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    rv_imm_gen #(
        .REG_DATA_WIDTH(REG_DATA_WIDTH)
    ) u_immGen (
        .i_instr (if_instr),
        .i_fmt   (w_fmt),
        .o_imm   (w_imm)
    );

`ifdef ID_FORWARD_WB_EN
    assign w_fwd1 = wb_en && (wb_rd == w_rs1) && (w_rs1 != '0);
    assign w_fwd2 = wb_en && (wb_rd == w_rs2) && (w_rs2 != '0);
`else
    assign w_fwd1 = 1'b0;
    assign w_fwd2 = 1'b0;
`endif

    assign w_haz1 = w_usesRs1 && (w_rs1 != '0) &&
                    ((r_busy[w_rs1] && !w_fwd1) ||
                     (r_exValid && r_exWe && (r_exRd == w_rs1)));
    assign w_haz2 = w_usesRs2 && (w_rs2 != '0) &&
                    ((r_busy[w_rs2] && !w_fwd2) ||
                     (r_exValid && r_exWe && (r_exRd == w_rs2)));

    assign if_ready = (!r_exValid || ex_ready) && !(w_haz1 || w_haz2) && !flush;
    assign w_accept = if_valid && if_ready;
    assign w_issue  = r_exValid && ex_ready && r_exWe && !flush;

    // Pick operand values: x0 reads as zero, otherwise regfile or bypassed writeback.
    always_comb begin
        w_rs1Val = dout_reg_0;
        w_rs2Val = dout_reg_1;
        if (w_fwd1) w_rs1Val = wb_data;
        if (w_fwd2) w_rs2Val = wb_data;
        if (w_rs1 == '0) w_rs1Val = '0;
        if (w_rs2 == '0) w_rs2Val = '0;
    end

    // Scoreboard: writeback clears a busy bit, issue sets one, and set wins on a tie.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_busy <= '0;
        end else begin
            if (wb_en && (wb_rd != '0)) r_busy[wb_rd] <= 1'b0;
            if (w_issue)                r_busy[r_exRd] <= 1'b1;
        end
    end

    // ID/EX slot: flush kills it, accept reloads it, a lone drain just empties it.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_exValid   <= 1'b0;
            r_exPc      <= '0;
            r_exRs1Val  <= '0;
            r_exRs2Val  <= '0;
            r_exImm     <= '0;
            r_exRd      <= '0;
            r_exOpcode  <= '0;
            r_exFunct3  <= '0;
            r_exFunct7  <= '0;
            r_exWe      <= 1'b0;
            r_exIllegal <= 1'b0;
        end else if (flush) begin
            r_exValid <= 1'b0;
        end else if (w_accept) begin
            r_exValid   <= 1'b1;
            r_exPc      <= if_pc;
            r_exRs1Val  <= w_rs1Val;
            r_exRs2Val  <= w_rs2Val;
            r_exImm     <= w_imm;
            r_exRd      <= w_rd;
            r_exOpcode  <= w_opcode;
            r_exFunct3  <= w_funct3;
            r_exFunct7  <= w_funct7;
            r_exWe      <= w_writesRd && (w_rd != '0);
            r_exIllegal <= w_illegal;
        end else if (r_exValid && ex_ready) begin
            r_exValid <= 1'b0;
        end
    end

    assign ex_valid   = r_exValid;
    assign ex_pc      = r_exPc;
    assign ex_rs1_val = r_exRs1Val;
    assign ex_rs2_val = r_exRs2Val;
    assign ex_imm     = r_exImm;
    assign ex_rd      = r_exRd;
    assign ex_opcode  = r_exOpcode;
    assign ex_funct3  = r_exFunct3;
    assign ex_funct7  = r_exFunct7;
    assign ex_we      = r_exWe;
    assign ex_illegal = r_exIllegal;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: self-checking bench for id_stage.
// Directed scenarios followed by randomized traffic, all checked against a
// behavioural model of the decode rules, scoreboard and ID/EX slot.
// Honours ID_FORWARD_WB_EN the same way the design does.
module tb_id_stage;

    localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6F, JALR = 7'h67;
    localparam logic [6:0] BRANCH = 7'h63, LOAD = 7'h03, STORE = 7'h23;
    localparam logic [6:0] OPIMM = 7'h13, OP = 7'h33;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [4:0]  read_reg_0, read_reg_1;
    logic [31:0] dout_reg_0, dout_reg_1;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
    logic [4:0]  ex_rd;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic [6:0]  ex_funct7;
    logic        ex_we, ex_illegal;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1v;
        logic [31:0] rs2v;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        we;
        logic        ill;
    } slot_t;

    logic [31:0] regs [32];
    slot_t       mSlot;
    bit          mBusy [32];
    logic [4:0]  wbQ [$];
    logic [6:0]  opcTable [11] = '{LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE,
                                   OPIMM, OP, 7'h7F, 7'h0B};
    int          errors = 0;
    int          checks = 0;

    assign dout_reg_0 = regs[read_reg_0];
    assign dout_reg_1 = regs[read_reg_1];

    always #5 CLK = ~CLK;

    id_stage #(.REG_DATA_WIDTH(32)) dut (
        .CLK(CLK), .RESET(RESET),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .read_reg_0(read_reg_0), .read_reg_1(read_reg_1),
        .dout_reg_0(dout_reg_0), .dout_reg_1(dout_reg_1),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc),
        .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm),
        .ex_rd(ex_rd), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
        .ex_funct7(ex_funct7), .ex_we(ex_we), .ex_illegal(ex_illegal)
    );

    // Compare one observed value against the model's requirement.
    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // Register usage and immediate of an instruction, from the ISA tables.
    function automatic void decodeModel(input logic [31:0] ins, output bit u1, output bit u2,
                                        output bit wr, output bit ill, output logic [31:0] imm);
        int s;
        s = ins;
        u1 = 0; u2 = 0; wr = 0; ill = 0; imm = 0;
        case (ins[6:0])
            LUI, AUIPC: begin wr = 1; imm = ins & 32'hFFFFF000; end
            JAL: begin
                wr = 1;
                imm = ((s >>> 31) * 1048576) + int'(ins[19:12]) * 4096 +
                      (ins[20] ? 2048 : 0) + int'(ins[30:21]) * 2;
            end
            JALR, LOAD, OPIMM: begin wr = 1; u1 = 1; imm = s >>> 20; end
            BRANCH: begin
                u1 = 1; u2 = 1;
                imm = ((s >>> 31) * 4096) + (ins[7] ? 2048 : 0) +
                      int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
            end
            STORE: begin u1 = 1; u2 = 1; imm = ((s >>> 25) * 32) + int'(ins[11:7]); end
            OP: begin wr = 1; u1 = 1; u2 = 1; end
            default: ill = 1;
        endcase
    endfunction

    // True when writeback data is usable for register r this very cycle.
    function automatic bit fwdHit(input logic [4:0] r);
`ifdef ID_FORWARD_WB_EN
        return wb_en && wb_rd == r && r != 0;
`else
        return 0;
`endif
    endfunction

    // Register r still awaits a result that ID must not read yet.
    function automatic bit pending(input logic [4:0] r);
        if (r == 0) return 0;
        if (mBusy[r] && !fwdHit(r)) return 1;
        return mSlot.valid && mSlot.we && mSlot.rd == r;
    endfunction

    function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] fromFile);
        if (r == 0) return 0;
        if (fwdHit(r)) return wb_data;
        return fromFile;
    endfunction

    task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                                 input logic rdy, input logic fl, input logic we,
                                 input logic [4:0] wr, input logic [31:0] wd);
        if_valid = v; if_instr = ins; if_pc = pc; ex_ready = rdy; flush = fl;
        wb_en = we; wb_rd = wr; wb_data = wd;
    endtask

    // One clock: check combinational outputs, step the model, check registered outputs.
    task automatic cycle();
        bit u1, u2, wr, ill, haz, expReady, accept, issue, wbHappen;
        logic [31:0] imm, wbD;
        logic [4:0] rs1, rs2, rd, wbR;
        @(negedge CLK);
        decodeModel(if_instr, u1, u2, wr, ill, imm);
        rs1 = if_instr[19:15]; rs2 = if_instr[24:20]; rd = if_instr[11:7];
        haz = (u1 && pending(rs1)) || (u2 && pending(rs2));
        expReady = (!mSlot.valid || ex_ready) && !haz && !flush;
        wbHappen = RESET && wb_en && wb_rd != 0;
        wbR = wb_rd; wbD = wb_data;
        if (!RESET) begin
            mSlot = '0;
            foreach (mBusy[i]) mBusy[i] = 0;
            wbQ.delete();
        end else begin
            checkOutput("if_ready", if_ready, expReady);
            checkOutput("read_regs", {read_reg_0, read_reg_1}, {rs1, rs2});
            accept = if_valid && expReady;
            issue = mSlot.valid && ex_ready && mSlot.we && !flush;
            if (wb_en && wb_rd != 0) mBusy[wb_rd] = 0;
            if (issue) begin
                mBusy[mSlot.rd] = 1;
                wbQ.push_back(mSlot.rd);
            end
            if (flush) mSlot.valid = 0;
            else if (accept) begin
                mSlot.valid = 1; mSlot.pc = if_pc; mSlot.imm = imm;
                mSlot.rs1v = operand(rs1, regs[rs1]);
                mSlot.rs2v = operand(rs2, regs[rs2]);
                mSlot.rd = rd; mSlot.opc = if_instr[6:0];
                mSlot.f3 = if_instr[14:12]; mSlot.f7 = if_instr[31:25];
                mSlot.we = wr && rd != 0; mSlot.ill = ill;
            end else if (mSlot.valid && ex_ready) mSlot.valid = 0;
        end
        @(posedge CLK);
        #1;
        if (wbHappen) regs[wbR] = wbD;
        checkOutput("ex_valid", ex_valid, mSlot.valid);
        checkOutput("ex_pc", ex_pc, mSlot.pc);
        checkOutput("ex_rs1_val", ex_rs1_val, mSlot.rs1v);
        checkOutput("ex_rs2_val", ex_rs2_val, mSlot.rs2v);
        checkOutput("ex_imm", ex_imm, mSlot.imm);
        checkOutput("ex_ctrl", {ex_rd, ex_opcode, ex_funct3, ex_funct7, ex_we, ex_illegal},
                    {mSlot.rd, mSlot.opc, mSlot.f3, mSlot.f7, mSlot.we, mSlot.ill});
    endtask

    initial begin
        logic [31:0] ins;
        logic [4:0]  wr;
        logic        wbe;
        mSlot = '0;
        foreach (regs[i]) regs[i] = $urandom;
        regs[3] = 32'h0;

        // Reset held for two cycles while fetch offers an instruction.
        RESET = 1'b0;
        applyStimulus(1, 32'h00500093, 32'h100, 1, 0, 0, 0, 0);
        cycle();
        cycle();
        RESET = 1'b1;
        applyStimulus(0, 32'h00500093, 32'h100, 1, 0, 0, 0, 0);
        cycle();
        checkOutput("reset_valid", ex_valid, 1'b0);
        checkOutput("reset_fields", {ex_pc, ex_imm, ex_rd, ex_we}, '0);

        // Back-to-back independent addi x1,5 / addi x2,7.
        applyStimulus(1, 32'h00500093, 32'h100, 1, 0, 0, 0, 0);
        cycle();
        checkOutput("b2b_imm0", ex_imm, 32'd5);
        applyStimulus(1, 32'h00700113, 32'h104, 1, 0, 0, 0, 0);
        cycle();
        checkOutput("b2b_imm1", ex_imm, 32'd7);
        checkOutput("b2b_valid", ex_valid, 1'b1);

        // RAW: addi x3,x0,1 then add x4,x3,x3 waits for x3's writeback.
        applyStimulus(1, 32'h00100193, 32'h108, 1, 0, 0, 0, 0);
        cycle();
        applyStimulus(1, 32'h00318233, 32'h10C, 1, 0, 0, 0, 0);
        cycle();
        cycle();
        applyStimulus(1, 32'h00318233, 32'h10C, 1, 0, 1, 5'd3, 32'h55);
        cycle();
`ifndef ID_FORWARD_WB_EN
        checkOutput("raw_still_stalled", ex_valid, 1'b0);
        applyStimulus(1, 32'h00318233, 32'h10C, 1, 0, 0, 0, 0);
        cycle();
`endif
        checkOutput("raw_accept", {ex_valid, ex_rd}, {1'b1, 5'd4});
        checkOutput("raw_rs1_val", ex_rs1_val, 32'h55);
        applyStimulus(0, 32'h0, 32'h0, 1, 0, 0, 0, 0);
        cycle();

        // Backpressure: slot held three cycles, then the next instruction loads.
        applyStimulus(1, 32'h00900293, 32'h110, 0, 0, 0, 0, 0);
        cycle();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 32'h00300313, 32'h114, 0, 0, 0, 0, 0);
            cycle();
            checkOutput("bp_hold", {ex_valid, ex_imm, ex_pc}, {1'b1, 32'd9, 32'h110});
        end
        applyStimulus(1, 32'h00300313, 32'h114, 1, 0, 0, 0, 0);
        cycle();
        checkOutput("bp_release", {ex_imm, ex_pc}, {32'd3, 32'h114});

        // Flush kills the held addi x6 and the offered addi x7.
        applyStimulus(1, 32'h00400393, 32'h118, 0, 1, 0, 0, 0);
        cycle();
        checkOutput("flush_valid", ex_valid, 1'b0);
        applyStimulus(1, 32'h00638433, 32'h11C, 1, 0, 0, 0, 0);
        cycle();
        checkOutput("post_flush_no_stall", {ex_valid, ex_rd}, {1'b1, 5'd8});

        // Immediate corner cases and an illegal opcode that reads a busy register.
        applyStimulus(1, 32'hFE000EE3, 32'h120, 1, 0, 0, 0, 0);
        cycle();
        checkOutput("beq_imm", ex_imm, 32'hFFFFFFFC);
        applyStimulus(1, 32'h123454B7, 32'h124, 1, 0, 0, 0, 0);
        cycle();
        checkOutput("lui_imm", ex_imm, 32'h12345000);
        applyStimulus(1, 32'h0084007F, 32'h128, 1, 0, 0, 0, 0);
        cycle();
        checkOutput("illegal", {ex_valid, ex_illegal, ex_we}, {1'b1, 1'b1, 1'b0});

        // Fresh reset, then randomized traffic over a small register window.
        RESET = 1'b0;
        applyStimulus(0, 32'h0, 32'h0, 0, 0, 0, 0, 0);
        cycle();
        RESET = 1'b1;
        for (int n = 0; n < 400; n++) begin
            ins = $urandom;
            ins[6:0] = opcTable[$urandom_range(0, 10)];
            ins[11:7] = 5'($urandom_range(0, 7));
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
            wbe = 0;
            wr = 0;
            if (wbQ.size() > 0 && $urandom_range(0, 1) == 1) begin
                wbe = 1;
                wr = wbQ.pop_front();
            end else if ($urandom_range(0, 15) == 0) begin
                wbe = 1;
            end
            applyStimulus($urandom_range(0, 3) != 0, ins, $urandom, $urandom_range(0, 2) != 0,
                          $urandom_range(0, 15) == 0, wbe, wr, $urandom);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
